// File: rtl/usb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sched
// Description : USB transmit scheduler; arbitrates handshake vs data packets,
//               drives the transmit controller, enforces IPG and a watchdog.
//               Optional build macro: USB_TX_SCHED_RETRY_EN (one data retry).
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sched #(
    parameter int IPG_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req_i,
    input  logic [1:0] hs_type_i,
    input  logic       data_req_i,
    input  logic       tx_complete_i,
    output logic       tx_ena_o,
    output logic       ack_prep_o,
    output logic       tx_ack_o,
    output logic       tx_nack_o,
    output logic       stall_o,
    output logic       hs_grant_o,
    output logic       data_grant_o,
    output logic       hs_done_o,
    output logic       data_done_o,
    output logic       tx_busy_o,
    output logic       timeout_err_o
);

    localparam int c_GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES + 1) : 1;
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(IPG_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);

    localparam logic [1:0] c_HS_ACK   = 2'b01;
    localparam logic [1:0] c_HS_NAK   = 2'b10;
    localparam logic [1:0] c_HS_STALL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE_HS   = 3'd1,
        S_WAIT_HS    = 3'd2,
        S_ISSUE_DATA = 3'd3,
        S_WAIT_DATA  = 3'd4,
        S_GAP        = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_GAP_W-1:0]   gap_q, gap_d;
    logic [c_WD_W-1:0]    wd_q, wd_d;
    logic                 retry_used_q, retry_used_d;
    logic                 retry_pend_q, retry_pend_d;

    logic tx_ena_q, tx_ena_d;
    logic ack_prep_q, ack_prep_d;
    logic tx_ack_q, tx_ack_d;
    logic tx_nack_q, tx_nack_d;
    logic stall_q, stall_d;
    logic hs_grant_q, hs_grant_d;
    logic data_grant_q, data_grant_d;
    logic hs_done_q, hs_done_d;
    logic data_done_q, data_done_d;
    logic tx_busy_q, tx_busy_d;
    logic timeout_err_q, timeout_err_d;

    logic hs_live;
    logic wait_exit;

    // A request whose grant is already showing is not re-arbitrated.
    assign hs_live = hs_req_i && !hs_grant_q;

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        wd_d          = wd_q;
        retry_used_d  = retry_used_q;
        retry_pend_d  = retry_pend_q;
        tx_ena_d      = 1'b0;
        hs_grant_d    = 1'b0;
        data_grant_d  = 1'b0;
        hs_done_d     = 1'b0;
        data_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        ack_prep_d    = ack_prep_q;
        tx_ack_d      = tx_ack_q;
        tx_nack_d     = tx_nack_q;
        stall_d       = stall_q;
        wait_exit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hs_live) begin
                    hs_grant_d = 1'b1;
                    // The select registers double as the latched handshake type.
                    if (hs_type_i != 2'b00) begin
                        state_d    = S_ISSUE_HS;
                        ack_prep_d = 1'b1;
                        tx_ack_d   = (hs_type_i == c_HS_ACK);
                        tx_nack_d  = (hs_type_i == c_HS_NAK);
                        stall_d    = (hs_type_i == c_HS_STALL);
                    end
                end else if (data_req_i) begin
                    state_d      = S_ISSUE_DATA;
                    tx_ena_d     = 1'b1;
                    data_grant_d = 1'b1;
                    retry_used_d = 1'b0;
                end
            end
            S_ISSUE_HS: begin
                state_d = S_WAIT_HS;
                wd_d    = '0;
            end
            S_ISSUE_DATA: begin
                state_d = S_WAIT_DATA;
                wd_d    = '0;
            end
            S_WAIT_HS, S_WAIT_DATA: begin
                wd_d = wd_q + c_WD_ONE;
                if (tx_complete_i) begin
                    wait_exit   = 1'b1;
                    hs_done_d   = (state_q == S_WAIT_HS);
                    data_done_d = (state_q == S_WAIT_DATA);
                end else if (wd_q == c_WD_LAST) begin
                    wait_exit     = 1'b1;
                    timeout_err_d = 1'b1;
`ifdef USB_TX_SCHED_RETRY_EN
                    if (state_q == S_WAIT_DATA && !retry_used_q) begin
                        retry_used_d = 1'b1;
                        retry_pend_d = 1'b1;
                    end
`endif
                end
                if (wait_exit) begin
                    ack_prep_d = 1'b0;
                    tx_ack_d   = 1'b0;
                    tx_nack_d  = 1'b0;
                    stall_d    = 1'b0;
                end
            end
            S_GAP: begin
                if (gap_q <= c_GAP_ONE) begin
                    if (retry_pend_q) begin
                        state_d      = S_ISSUE_DATA;
                        tx_ena_d     = 1'b1;
                        retry_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - c_GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving WAIT: through the gap, or straight on when no gap is configured.
        if (wait_exit) begin
            if (IPG_CYCLES == 0) begin
                if (retry_pend_d) begin
                    state_d      = S_ISSUE_DATA;
                    tx_ena_d     = 1'b1;
                    retry_pend_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                state_d = S_GAP;
                gap_d   = c_GAP_LOAD;
            end
        end

        tx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gap_q         <= '0;
            wd_q          <= '0;
            retry_used_q  <= 1'b0;
            retry_pend_q  <= 1'b0;
            tx_ena_q      <= 1'b0;
            ack_prep_q    <= 1'b0;
            tx_ack_q      <= 1'b0;
            tx_nack_q     <= 1'b0;
            stall_q       <= 1'b0;
            hs_grant_q    <= 1'b0;
            data_grant_q  <= 1'b0;
            hs_done_q     <= 1'b0;
            data_done_q   <= 1'b0;
            tx_busy_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            wd_q          <= wd_d;
            retry_used_q  <= retry_used_d;
            retry_pend_q  <= retry_pend_d;
            tx_ena_q      <= tx_ena_d;
            ack_prep_q    <= ack_prep_d;
            tx_ack_q      <= tx_ack_d;
            tx_nack_q     <= tx_nack_d;
            stall_q       <= stall_d;
            hs_grant_q    <= hs_grant_d;
            data_grant_q  <= data_grant_d;
            hs_done_q     <= hs_done_d;
            data_done_q   <= data_done_d;
            tx_busy_q     <= tx_busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_ena_o      = tx_ena_q;
    assign ack_prep_o    = ack_prep_q;
    assign tx_ack_o      = tx_ack_q;
    assign tx_nack_o     = tx_nack_q;
    assign stall_o       = stall_q;
    assign hs_grant_o    = hs_grant_q;
    assign data_grant_o  = data_grant_q;
    assign hs_done_o     = hs_done_q;
    assign data_done_o   = data_done_q;
    assign tx_busy_o     = tx_busy_q;
    assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire
